// File: rtl/spi_responder_pkg.sv
// spi_responder_pkg: shared FSM state encoding and default word lengths
package spi_responder_pkg;
  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t ACTIVE = 1'b1;
  localparam int DEF_RX_BITS = 32;
  localparam int DEF_TX_BITS = 8;
endpackage

// File: rtl/spi_responder_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with rise/fall detect on the synchronized value
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= {3{RST_VAL}};
    else        s_q <= {s_q[1:0], d_i};
  assign q_o    = s_q[1];
  assign rise_o = s_q[1] & ~s_q[2];
  assign fall_o = ~s_q[1] & s_q[2];
endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI target that samples mosi and advances miso on sclk falling edges, with a one-word tx holding buffer
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int RX_BITS = DEF_RX_BITS,
  parameter int TX_BITS = DEF_TX_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  input  logic [TX_BITS-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_underrun,
  output logic               frame_abort
);
  localparam int RXW = $clog2(RX_BITS);
  localparam int TXW = $clog2(TX_BITS);
  logic sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_q_unused, sclk_rise_unused, cs_q_unused, mosi_rise_unused, mosi_fall_unused;
  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .q_o(sclk_q_unused), .rise_o(sclk_rise_unused), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d_i(cs_n),
    .q_o(cs_q_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );
  state_t             state_q, state_d;
  logic [RX_BITS-2:0] rx_sh_q, rx_sh_d;
  logic [RXW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [RX_BITS-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic [TX_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [TXW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [TX_BITS-1:0] buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               underrun_q, underrun_d;
  logic               abort_q, abort_d;
  logic start, stop, shift, rx_last, tx_last, consume, hs;
  logic [TX_BITS-1:0] tx_word;
  assign start   = (state_q == IDLE) & cs_fall;
  assign stop    = (state_q == ACTIVE) & cs_rise;
  assign shift   = (state_q == ACTIVE) & ~cs_rise & sclk_fall;
  assign rx_last = rx_cnt_q == RXW'(RX_BITS - 1);
  assign tx_last = tx_cnt_q == TXW'(TX_BITS - 1);
  assign consume = start | (shift & tx_last);
  assign hs      = tx_valid & ~buf_full_q;
  assign tx_word = buf_full_q ? buf_q : '1;
  // a handshake on the consuming edge refills the buffer for the following word
  always_comb begin
    state_d    = start ? ACTIVE : stop ? IDLE : state_q;
    rx_sh_d    = shift ? {rx_sh_q[RX_BITS-3:0], mosi_s} : rx_sh_q;
    rx_cnt_d   = (start | stop) ? '0 : shift ? (rx_last ? '0 : rx_cnt_q + 1'b1) : rx_cnt_q;
    rx_data_d  = (shift & rx_last) ? {rx_sh_q, mosi_s} : rx_data_q;
    rx_valid_d = shift & rx_last;
    tx_cnt_d   = (start | stop) ? '0 : shift ? (tx_last ? '0 : tx_cnt_q + 1'b1) : tx_cnt_q;
    tx_sh_d    = consume ? tx_word : stop ? '1 : shift ? {tx_sh_q[TX_BITS-2:0], 1'b1} : tx_sh_q;
    buf_d      = hs ? tx_data : buf_q;
    buf_full_d = hs | (buf_full_q & ~consume);
    underrun_d = consume & ~buf_full_q;
    abort_d    = stop & (rx_cnt_q != '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_sh_q    <= rx_sh_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  // tx_sh_q is all-ones whenever idle, so miso idles high
  assign miso        = tx_sh_q[TX_BITS-1];
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~buf_full_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed frames with rx-word and miso-bit scoreboards
module tb_spi_responder;
  logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        miso, rx_valid, tx_ready, tx_underrun, frame_abort;
  logic [31:0] rx_data;
  int checks = 0, fails = 0, u_cnt = 0, ab_cnt = 0, rv_cnt = 0;
  logic [31:0] rx_exp[$];
  logic        miso_exp[$];
  spi_responder dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (tx_underrun) u_cnt++;
    if (frame_abort) ab_cnt++;
    if (rx_valid) begin
      rv_cnt++;
      chk("rx_word", 64'(rx_data), rx_exp.size() != 0 ? 64'(rx_exp.pop_front()) : 64'hx);
    end
  end
  task automatic zero();
    u_cnt = 0; ab_cnt = 0; rv_cnt = 0;
  endtask
  task automatic xbit(input logic b);
    logic e;
    mosi = b;
    if (miso_exp.size() != 0) begin
      e = miso_exp.pop_front();
      chk("miso_bit", 64'(miso), 64'(e));
    end
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic send(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) xbit(v[i]);
  endtask
  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) miso_exp.push_back(v[i]);
  endtask
  task automatic cs_lo();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic cs_hi();
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miso", 64'(miso), 64'd1);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd1);
    chk("rst_underrun", 64'(tx_underrun), 64'd0);
    chk("rst_abort", 64'(frame_abort), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // host word 0xA5 then underrun ones
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t1_buffered", 64'(tx_ready), 64'd0);
    push_bits(64'hA5, 8); push_bits('1, 24);
    rx_exp.push_back(32'hDEADBEEF);
    zero();
    cs_lo();
    chk("t1_ready_after_load", 64'(tx_ready), 64'd1);
    chk("t1_no_underrun_start", 64'(u_cnt), 64'd0);
    send(64'hDEADBEEF, 32);
    cs_hi();
    chk("t1_rx_data", 64'(rx_data), 64'hDEADBEEF);
    chk("t1_rv_cnt", 64'(rv_cnt), 64'd1);
    chk("t1_underruns", 64'(u_cnt), 64'd4);
    chk("t1_abort", 64'(ab_cnt), 64'd0);
    // no host data at all
    zero();
    push_bits('1, 32);
    rx_exp.push_back(32'h0F0F0F0F);
    cs_lo();
    chk("t2_underrun_start", 64'(u_cnt), 64'd1);
    send(64'h0F0F0F0F, 32);
    cs_hi();
    chk("t2_rv_cnt", 64'(rv_cnt), 64'd1);
    chk("t2_rx_data", 64'(rx_data), 64'h0F0F0F0F);
    chk("t2_abort", 64'(ab_cnt), 64'd0);
    // partial frame of 12 bits
    zero();
    push_bits('1, 12);
    cs_lo();
    send(64'hABC, 12);
    cs_hi();
    chk("t3_abort", 64'(ab_cnt), 64'd1);
    chk("t3_rv_cnt", 64'(rv_cnt), 64'd0);
    chk("t3_rx_hold", 64'(rx_data), 64'h0F0F0F0F);
    // back-to-back words
    zero();
    push_bits('1, 64);
    rx_exp.push_back(32'h12345678); rx_exp.push_back(32'h9ABCDEF0);
    cs_lo();
    send(64'h123456789ABCDEF0, 64);
    cs_hi();
    chk("t4_rv_cnt", 64'(rv_cnt), 64'd2);
    chk("t4_rx_data", 64'(rx_data), 64'h9ABCDEF0);
    chk("t4_abort", 64'(ab_cnt), 64'd0);
    // reset mid-frame
    zero();
    push_bits('1, 10);
    cs_lo();
    send(64'h2AA, 10);
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_miso", 64'(miso), 64'd1);
    chk("t5_rx_data", 64'(rx_data), 64'd0);
    chk("t5_rx_valid", 64'(rx_valid), 64'd0);
    chk("t5_tx_ready", 64'(tx_ready), 64'd1);
    chk("t5_underrun", 64'(tx_underrun), 64'd0);
    chk("t5_abort_pin", 64'(frame_abort), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_abort_cnt", 64'(ab_cnt), 64'd0);
    send(64'hF, 4);
    chk("t5_idle_miso", 64'(miso), 64'd1);
    chk("t5_idle_rv", 64'(rv_cnt), 64'd0);
    zero();
    push_bits('1, 32);
    rx_exp.push_back(32'h0BADF00D);
    cs_lo();
    send(64'h0BADF00D, 32);
    cs_hi();
    chk("t5_rv_cnt", 64'(rv_cnt), 64'd1);
    chk("t5_rx_after", 64'(rx_data), 64'h0BADF00D);
    chk("t5_abort_after", 64'(ab_cnt), 64'd0);
    // streamed host words 0x3C, 0xC3 (0x00 keeps the 16th-bit reload fed)
    zero();
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hC3;
    push_bits(64'h3C, 8); push_bits(64'hC3, 8);
    cs_lo();
    chk("t6_c3_buffered", 64'(tx_ready), 64'd0);
    tx_data = 8'h00;
    send(64'h0, 8);
    tx_valid = 1'b0;
    send(64'h0, 8);
    cs_hi();
    chk("t6_underruns", 64'(u_cnt), 64'd0);
    chk("t6_abort", 64'(ab_cnt), 64'd1);
    chk("t6_tx_ready", 64'(tx_ready), 64'd1);
    chk("miso_queue_drained", 64'(miso_exp.size()), 64'd0);
    chk("rx_queue_drained", 64'(rx_exp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 The module SHALL have parameter RX_BITS, default 32, meaning the MOSI word length (bits) that completes one receive word.
REQ-002 The module SHALL have parameter TX_BITS, default 8, meaning the MISO word length (bits) that completes one transmit word.
REQ-003 The module SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port sclk, input, 1, serial clock from the initiator, asynchronous to clk.
REQ-006 The module SHALL have port cs_n, input, 1, active-low frame select from the initiator, asynchronous to clk.
REQ-007 The module SHALL have port mosi, input, 1, serial data from the initiator, MSB first.
REQ-008 The module SHALL have port miso, output, 1, serial data to the initiator, MSB first.
REQ-009 The module SHALL have port rx_data, output, RX_BITS, last completed receive word.
REQ-010 The module SHALL have port rx_valid, output, 1, one-clk pulse when rx_data updates.
REQ-011 The module SHALL have port tx_data, input, TX_BITS, next transmit word from host.
REQ-012 The module SHALL have port tx_valid, input, 1, host offers tx_data.
REQ-013 The module SHALL have port tx_ready, output, 1, holding buffer empty; transfer occurs when tx_valid and tx_ready are high on the same clk edge.
REQ-014 The module SHALL have port tx_underrun, output, 1, one-clk pulse when a word is started with no buffered data.
REQ-015 The module SHALL have port frame_abort, output, 1, one-clk pulse when cs_n rises with a partial receive word.

Function
REQ-016 sclk, cs_n, mosi SHALL each pass a 2-flop synchronizer; edges SHALL be detected from the synchronized values; sclk frequency SHALL be at most clk/8.
REQ-017 The FSM SHALL have states IDLE (cs_n high) and ACTIVE (cs_n low); IDLE->ACTIVE on synchronized cs_n fall, ACTIVE->IDLE on synchronized cs_n rise.
REQ-018 On IDLE->ACTIVE the shifter SHALL load the holding buffer (or 0xFF-pattern all-ones if empty, pulsing tx_underrun), clear the rx and tx bit counters, and drive miso with the loaded MSB.
REQ-019 In ACTIVE, on each synchronized sclk falling edge the responder SHALL shift mosi into the rx shift register LSB and advance miso to the next tx bit.
REQ-020 miso SHALL change no later than 4 clk cycles after the sclk falling pin edge, so it is stable for the initiator's rising-edge sample.
REQ-021 After RX_BITS sampled bits rx_data SHALL load the shift register and rx_valid SHALL pulse on the next clk; the counter SHALL wrap to 0 and reception continue for back-to-back words.
REQ-022 After TX_BITS bits the shifter SHALL reload from the holding buffer (all-ones plus tx_underrun if empty) and continue; tx_ready SHALL rise the clk after the buffer is consumed.
REQ-023 cs_n rise with rx counter nonzero SHALL pulse frame_abort, discard the partial word, and leave rx_data unchanged.
REQ-024 In IDLE miso SHALL be driven 1 and sclk/mosi activity SHALL be ignored.
REQ-025 A tx handshake coinciding with a buffer consume SHALL refill the buffer the same edge (tx_ready stays high only if empty after both).
REQ-026 rx_data SHALL hold until the next completed word; there is no rx back-pressure.

Reset
REQ-027 While rst_n is low: state IDLE, counters 0, holding buffer empty, rx_data 0, rx_valid 0, tx_ready 1, tx_underrun 0, frame_abort 0, miso 1, synchronizers at idle values (cs_n=1, sclk=0).
REQ-028 Reset asserted mid-frame SHALL abort without frame_abort pulse; after release the FSM SHALL wait for a fresh cs_n fall.

Structure
REQ-029 A shared package SHALL hold FSM state typedef and default RX_BITS/TX_BITS constants.
REQ-030 One sub-module, spi_sync_edge (2-flop sync plus rise/fall detect), SHALL be instantiated for sclk, cs_n and mosi.

Verification
REQ-031 Host writes 0xA5; frame of 32 sclk with mosi 0xDEADBEEF -> rx_data 0xDEADBEEF, one rx_valid, miso bits 1,0,1,0,0,1,0,1 on first 8 rising edges, then 1s with tx_underrun.
REQ-032 cs_n low, no tx_data -> miso all ones, tx_underrun pulse at frame start.
REQ-033 cs_n rises after 12 bits -> frame_abort pulse, rx_valid absent, rx_data unchanged.
REQ-034 64 contiguous bits 0x12345678,0x9ABCDEF0 -> two rx_valid pulses with those values in order.
REQ-035 rst_n pulsed low after 10 bits -> all outputs at reset values, next full frame received correctly.
REQ-036 tx_valid held with 0x3C,0xC3 during 16-bit frame -> miso 0x3C then 0xC3, no underrun.
